rf_read_arbiter: RTL



---
 rtl/miniRISC_pkg.sv | 22 ++
 rtl/rf_read_arbiter_if.sv | 41 ++++
 rtl/rf_arb_wait_counter.sv | 32 +++
 rtl/rf_read_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/miniRISC_pkg.sv
// miniRISC_pkg: definitions shared by the register-file read arbiter
// and its sub-blocks.
//   - REG_ADDR_W / REG_DATA_W : register-file index and data widths.
//   - arb_state_t             : state of the debug-read sequencer.
package miniRISC_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Debug read sequencer:
  //   IDLE -> PEND (request latched)
  //   PEND -> CAPT (read port granted to debug)
  //   CAPT -> RESP (RF data captured)
  //   RESP -> IDLE (response accepted)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rf_read_arbiter_if.sv
// rf_read_arbiter_if: bundles every signal around the shared RF read port.
//   Core side  : core_rd_en, core_rd_addr -> core_rd_data, core_stall
//   Debug side : dbg_req_valid/ready/addr, dbg_rsp_valid/ready/data
//   RF side    : rf_rd_addr -> rf_rd_data (RF registers the address)
// Modports:
//   slave  - the arbiter
//   master - the surrounding core, debug requester and register file
interface rf_read_arbiter_if #(
  parameter int DATA_W = miniRISC_pkg::REG_DATA_W,
  parameter int ADDR_W = miniRISC_pkg::REG_ADDR_W
);
  logic              core_rd_en;
  logic [ADDR_W-1:0] core_rd_addr;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_stall;

  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic              dbg_rsp_valid;
  logic              dbg_rsp_ready;
  logic [DATA_W-1:0] dbg_rsp_data;

  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;

  modport slave (
    input  core_rd_en, core_rd_addr, dbg_req_valid, dbg_req_addr,
           dbg_rsp_ready, rf_rd_data,
    output core_rd_data, core_stall, dbg_req_ready, dbg_rsp_valid,
           dbg_rsp_data, rf_rd_addr
  );

  modport master (
    output core_rd_en, core_rd_addr, dbg_req_valid, dbg_req_addr,
           dbg_rsp_ready, rf_rd_data,
    input  core_rd_data, core_stall, dbg_req_ready, dbg_rsp_valid,
           dbg_rsp_data, rf_rd_addr
  );

endinterface

// File: rtl/rf_arb_wait_counter.sv
// rf_arb_wait_counter: counts how long a debug request has been waiting.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart at 0 (takes priority over inc)
//   inc      : count up by one, holding at MAX
//   at_max   : count has reached MAX
module rf_arb_wait_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != W'(MAX))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign at_max = (cnt_reg == W'(MAX));

endmodule

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares the single synchronous RF read port between the
// core datapath (priority) and a debug requester.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rf_read_arbiter_if.slave (core, debug and RF signals)
//   dbg_grant_cnt, forced_grant_cnt : only when RF_ARB_STATS_EN is
//              defined; 16-bit wrapping counts of debug grants and of
//              grants forced by the wait limit.
// A pending debug read takes the port in the first cycle the core does
// not read, or after MAX_WAIT waiting cycles, stalling the core once.
// rf_rd_addr, core_stall and core_rd_data are combinational; the dbg_*
// outputs are registered.
module rf_read_arbiter
  import miniRISC_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst,
  rf_read_arbiter_if.slave bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0] dbg_grant_cnt,
  output logic [15:0] forced_grant_cnt
`endif
);

  arb_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  logic at_max;
  logic grant;
  logic cnt_clr;
  logic cnt_inc;

  // Debug owns the port only in the PEND cycle where the core is idle
  // or the wait limit has been reached.
  assign grant   = (state_reg == ST_PEND) && (!bus.core_rd_en || at_max);
  assign cnt_clr = (state_reg == ST_IDLE) && bus.dbg_req_valid;
  assign cnt_inc = (state_reg == ST_PEND) && !grant;

  rf_arb_wait_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .at_max (at_max)
  );

  assign bus.rf_rd_addr    = grant ? addr_reg : bus.core_rd_addr;
  assign bus.core_stall    = grant & bus.core_rd_en;
  assign bus.core_rd_data  = bus.rf_rd_data;
  assign bus.dbg_req_ready = req_ready_reg;
  assign bus.dbg_rsp_valid = rsp_valid_reg;
  assign bus.dbg_rsp_data  = rsp_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.dbg_req_valid) begin
            addr_reg      <= bus.dbg_req_addr;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (grant) begin
            state_reg <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          // The RF registered the debug address at the grant edge, so its
          // output now holds the requested register.
          rsp_data_reg  <= bus.rf_rd_data;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.dbg_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [15:0] grant_cnt_reg;
  logic [15:0] forced_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_reg  <= '0;
      forced_cnt_reg <= '0;
    end else if (grant) begin
      grant_cnt_reg <= grant_cnt_reg + 16'd1;
      if (at_max) begin
        forced_cnt_reg <= forced_cnt_reg + 16'd1;
      end
    end
  end

  assign dbg_grant_cnt    = grant_cnt_reg;
  assign forced_grant_cnt = forced_cnt_reg;
`endif

endmodule
